// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 single-outstanding INCR burst responder driving a synchronous single-port SRAM
module axi_sram_slave #(
  parameter int ID_BITS       = 8,
  parameter int DATA_BITS     = 32,
  parameter int LEN_BITS      = 4,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [ID_BITS-1:0]       ARID_S,
  input  logic [31:0]              ARADDR_S,
  input  logic [LEN_BITS-1:0]      ARLEN_S,
  input  logic [2:0]               ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  output logic [ID_BITS-1:0]       RID_S,
  output logic [DATA_BITS-1:0]     RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  input  logic [ID_BITS-1:0]       AWID_S,
  input  logic [31:0]              AWADDR_S,
  input  logic [LEN_BITS-1:0]      AWLEN_S,
  input  logic [2:0]               AWSIZE_S,
  input  logic [1:0]               AWBURST_S,
  input  logic                     AWVALID_S,
  output logic                     AWREADY_S,
  input  logic [DATA_BITS-1:0]     WDATA_S,
  input  logic [DATA_BITS/8-1:0]   WSTRB_S,
  input  logic                     WLAST_S,
  input  logic                     WVALID_S,
  output logic                     WREADY_S,
  output logic [ID_BITS-1:0]       BID_S,
  output logic [1:0]               BRESP_S,
  output logic                     BVALID_S,
  input  logic                     BREADY_S,
  output logic                     CEB,
  output logic                     WEB,
  output logic [DATA_BITS-1:0]     BWEB,
  output logic [MEM_ADDR_BITS-1:0] A,
  output logic [DATA_BITS-1:0]     DI,
  input  logic [DATA_BITS-1:0]     DO
);

  typedef enum logic [2:0] {IDLE, R_READ, R_DATA, W_DATA, W_RESP} state_t;

  state_t                   r_state, w_next;
  logic [ID_BITS-1:0]       r_id;
  logic [LEN_BITS-1:0]      r_len;
  logic [LEN_BITS-1:0]      r_beat;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic                     r_over;
  logic                     r_rd_first;
  logic [DATA_BITS-1:0]     r_rdata;

  logic                     w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_b_hs;
  logic                     w_wr;
  logic                     w_last;
  logic [DATA_BITS-1:0]     w_mask;
  logic                     w_unused;

  assign w_unused = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S,
                      ARADDR_S[31:MEM_ADDR_BITS+2], ARADDR_S[1:0],
                      AWADDR_S[31:MEM_ADDR_BITS+2], AWADDR_S[1:0]};

  assign w_aw_hs = AWVALID_S & AWREADY_S;
  assign w_ar_hs = ARVALID_S & ARREADY_S;
  assign w_w_hs  = WVALID_S & WREADY_S;
  assign w_r_hs  = RVALID_S & RREADY_S;
  assign w_b_hs  = BVALID_S & BREADY_S;
  assign w_last  = (r_beat == r_len);
  // Beats past AxLEN are still handshaked but must not touch the SRAM.
  assign w_wr    = w_w_hs & ~r_over;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_BITS; i++) w_mask[i] = ~WSTRB_S[i/8];
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs) w_next = W_DATA;
               else if (w_ar_hs) w_next = R_READ;
      R_READ:  w_next = R_DATA;
      R_DATA:  if (w_r_hs) w_next = w_last ? IDLE : R_READ;
      W_DATA:  if (w_w_hs && WLAST_S) w_next = W_RESP;
      W_RESP:  if (w_b_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready outputs are gated by reset so they read 0 for the whole time reset is held.
  always_comb begin
    AWREADY_S = 1'b0;
    ARREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    BVALID_S  = 1'b0;
    CEB       = 1'b1;
    WEB       = 1'b1;
    BWEB      = '1;
    DI        = '0;
    case (r_state)
      IDLE: begin
        AWREADY_S = ~ARESETn;
        ARREADY_S = ~ARESETn & ~AWVALID_S;
      end
      R_READ: CEB = 1'b0;
      R_DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = w_last;
      end
      W_DATA: begin
        WREADY_S = 1'b1;
        if (w_wr) begin
          CEB  = 1'b0;
          WEB  = 1'b0;
          BWEB = w_mask;
          DI   = WDATA_S;
        end
      end
      W_RESP: BVALID_S = 1'b1;
      default: ;
    endcase
  end

  assign A       = r_addr;
  assign RID_S   = r_id;
  assign BID_S   = r_id;
  assign RRESP_S = 2'b00;
  assign BRESP_S = 2'b00;
  // DO is only valid during the first R_DATA cycle; afterwards the captured copy is shown.
  assign RDATA_S = (r_state == R_DATA && r_rd_first) ? DO : r_rdata;

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      r_id       <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_addr     <= '0;
      r_over     <= 1'b0;
      r_rd_first <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_id   <= AWID_S;
            r_len  <= AWLEN_S;
            r_addr <= AWADDR_S[MEM_ADDR_BITS+1:2];
            r_beat <= '0;
            r_over <= 1'b0;
          end else if (w_ar_hs) begin
            r_id   <= ARID_S;
            r_len  <= ARLEN_S;
            r_addr <= ARADDR_S[MEM_ADDR_BITS+1:2];
            r_beat <= '0;
            r_over <= 1'b0;
          end
        end
        R_READ: r_rd_first <= 1'b1;
        R_DATA: begin
          if (r_rd_first) begin
            r_rdata    <= DO;
            r_rd_first <= 1'b0;
          end
          if (w_r_hs && !w_last) begin
            r_addr <= r_addr + MEM_ADDR_BITS'(1);
            r_beat <= r_beat + LEN_BITS'(1);
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_addr <= r_addr + MEM_ADDR_BITS'(1);
            r_beat <= r_beat + LEN_BITS'(1);
            if (w_last) r_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 responder that bridges one interconnect slave port to a single-port, synchronous, active-low-controlled SRAM macro. It serves the CPU-side masters (IM fetch, DM load/store) through the bus.
- Handles one outstanding transaction at a time: either an INCR read burst or an INCR write burst, up to 16 beats, word-sized.
- Instantiated once per memory (IM, DM) behind the interconnect slave ports.

## Interface
Parameters:
- ID_BITS, 8, slave-side ID width (master ID + interconnect tag)
- DATA_BITS, 32, data width; one SRAM word per beat
- LEN_BITS, 4, AxLEN width
- MEM_ADDR_BITS, 14, SRAM word-address width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset; asynchronous, active-high
- ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  in  ID_BITS/32/LEN_BITS/3/2  read address
- ARVALID_S  in  1; ARREADY_S  out  1  read address handshake
- RID_S  out  ID_BITS; RDATA_S  out  DATA_BITS; RRESP_S  out  2; RLAST_S  out  1; RVALID_S  out  1; RREADY_S  in  1  read data
- AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S  in  ID_BITS/32/LEN_BITS/3/2  write address
- AWVALID_S  in  1; AWREADY_S  out  1  write address handshake
- WDATA_S  in  DATA_BITS; WSTRB_S  in  DATA_BITS/8; WLAST_S  in  1; WVALID_S  in  1; WREADY_S  out  1  write data
- BID_S  out  ID_BITS; BRESP_S  out  2; BVALID_S  out  1; BREADY_S  in  1  write response
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low
- BWEB  out  DATA_BITS  SRAM per-bit write mask, active-low
- A  out  MEM_ADDR_BITS  SRAM word address
- DI  out  DATA_BITS  SRAM write data
- DO  in  DATA_BITS  SRAM read data, valid the cycle after a CEB-low/WEB-high access

## Operation
- FSM states: IDLE, R_READ, R_DATA, W_DATA, W_RESP.
- IDLE:
  - AWREADY_S=1.
  - ARREADY_S = ~AWVALID_S, so write wins a simultaneous request.
  - On an AW or AR handshake, latch ID, LEN, and word address = AxADDR[MEM_ADDR_BITS+1:2].
  - Clear beat counter.
  - Go to W_DATA (write) or R_READ (read).
- AxSIZE and AxBURST are ignored; every burst is treated as INCR word.
- R_READ (one cycle):
  - CEB=0, WEB=1, A=current address.
  - Always go to R_DATA; DO is captured into the RDATA register at the R_DATA entry edge + SRAM latency, i.e. sampled at the end of the first R_DATA cycle and held.
  - RDATA_S is driven from this register. The register is loaded only in the first R_DATA cycle and holds under backpressure.
- R_DATA:
  - RVALID_S=1, RID_S=latched ID, RRESP_S=2'b00, RLAST_S=(beat==LEN). CEB=1.
  - On R handshake: if RLAST_S go to IDLE; else address+1, beat+1, go to R_READ.
- W_DATA:
  - WREADY_S=1.
  - On a W handshake, in the same cycle drive CEB=0, WEB=0, A=current address, DI=WDATA_S, BWEB bit i = ~WSTRB_S[i/8].
  - Then address+1, beat+1.
  - If WLAST_S, go to W_RESP.
  - Beats after beat>LEN are accepted with CEB=1 (no write).
  - Outside a W handshake: CEB=1, WEB=1, BWEB all ones.
- W_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S=2'b00. On BREADY_S go to IDLE.
- Address increment wraps modulo 2^MEM_ADDR_BITS. Beat counter is LEN_BITS wide.

## Timing
- Reset values:
  - All READY/VALID outputs, RLAST_S, RRESP_S, BRESP_S = 0.
  - RID_S, BID_S, RDATA_S, A, DI = 0.
  - CEB=1, WEB=1, BWEB all ones.
  - State IDLE.
- Asserting ARESETn mid-burst:
  - Forces IDLE and all reset values immediately.
  - No SRAM write occurs after assertion.
  - The partial burst is abandoned, with no response.
- Read latency: AR handshake at edge k → R_READ in cycle k+1 → RVALID_S in cycle k+2. Each later beat takes 2 cycles when RREADY_S is held high.
- Write: first W handshake possible in cycle k+1 after AW handshake at edge k. The SRAM write happens in the handshake cycle. BVALID_S rises in the cycle after the WLAST beat.
- VALID outputs never drop before their handshake. RDATA_S, RID_S, RLAST_S, BID_S are stable while VALID is high.
- Back-to-back: the earliest next AR/AW acceptance is the cycle after the final R or B handshake (IDLE lasts ≥1 cycle).

## Test plan
- Single read: SRAM[0x10]=0xDEADBEEF; ARADDR=0x40, ARLEN=0, ARID=0x12 → RVALID in cycle k+2, RDATA=0xDEADBEEF, RID=0x12, RLAST=1, RRESP=0; CEB low for exactly one cycle.
- 4-beat read with RREADY low for 3 cycles on beat 1: ARADDR=0x100 → RDATA=SRAM[0x40..0x43] in order, beat 1 held stable, RLAST only on beat 3, no extra SRAM reads while stalled.
- Strobed write: AWADDR=0x20, AWLEN=0, WDATA=0xAABBCCDD, WSTRB=4'b0101 → BWEB=32'hFF00FF00, A=0x8, WEB=0; BVALID next cycle, BRESP=0, BID=AWID.
- Simultaneous ARVALID and AWVALID in IDLE → AWREADY=1, ARREADY=0; the write completes (B handshake) before ARREADY rises; the read then returns the newly written data.
- Address wrap: AWADDR=0x0000FFFC, AWLEN=1 → SRAM writes to A=0x3FFF then A=0x0000.
- Reset mid-burst: assert ARESETn during beat 2 of an 8-beat write → CEB=1, WREADY=0, BVALID=0 immediately; after release, a single read returns correct data.
